// File: rtl/gl_pkg.sv
// Shared definitions for the triangle assembly stage: data widths, field
// offsets inside the packed vertex/color words, and the assembler state encoding.
package gl_pkg;

  localparam int VERTEX_W = 96;
  localparam int COLOR_W  = 96;
  localparam int ENTRY_W  = VERTEX_W + COLOR_W;

  // Field positions within a 96-bit vertex {x, y, z} or color {r, g, b}.
  localparam int X_HI = 95;
  localparam int Y_HI = 63;
  localparam int Z_HI = 31;
  localparam int R_HI = 95;
  localparam int G_HI = 63;
  localparam int B_HI = 31;
  localparam int FIELD_W = 32;

  typedef enum logic [1:0] {
    ASM0 = 2'd0,
    ASM1 = 2'd1,
    ASM2 = 2'd2,
    EMIT = 2'd3
  } asm_state_t;

endpackage

// File: rtl/vertex_sync_fifo.sv
// Single-clock FIFO holding {vertex, color} entries; read data is the entry at
// the read pointer, and a write becomes visible only after its clock edge.
module vertex_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              do_push;
  logic              do_pop;

  // Room is judged on the registered count, so a same-cycle pop never makes
  // space for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (ADDR_W+1)'(1);
      2'b01:   count_next = count - (ADDR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
      full  <= (count_next == (ADDR_W+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/triangle_assembler.sv
// Buffers transformed vertices, groups every three into a triangle and hands
// the triangle to the rasterizer.
module triangle_assembler
  import gl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_write_en,
  input  logic [VERTEX_W-1:0] vertex_in,
  input  logic [COLOR_W-1:0]  color_in,
  output logic                fifo_full,
  output logic [ADDR_W:0]     fifo_count,
  output logic                overflow,
  input  logic                flush,
  output logic                tri_valid,
  input  logic                tri_ready,
  output logic [VERTEX_W-1:0] tri_v0,
  output logic [VERTEX_W-1:0] tri_v1,
  output logic [VERTEX_W-1:0] tri_v2,
  output logic [COLOR_W-1:0]  tri_c0,
  output logic [COLOR_W-1:0]  tri_c1,
  output logic [COLOR_W-1:0]  tri_c2,
  output logic [1:0]          asm_state
);

  asm_state_t         state;
  logic [ENTRY_W-1:0] rdata;
  logic               fifo_empty;
  logic               pop;

  vertex_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_write_en),
    .pop   (pop),
    .wdata ({vertex_in, color_in}),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop       = !flush && (state != EMIT) && !fifo_empty;
  assign asm_state = state;

  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else if (fifo_write_en && fifo_full) overflow <= 1'b1;
  end

  // Handshake: tri_valid rises with the third slot load and the slots stay
  // frozen until a cycle with tri_valid && tri_ready; only flush or reset may
  // withdraw a triangle that has not been accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASM0;
      tri_valid <= 1'b0;
      tri_v0    <= '0;
      tri_v1    <= '0;
      tri_v2    <= '0;
      tri_c0    <= '0;
      tri_c1    <= '0;
      tri_c2    <= '0;
    end else if (flush) begin
      state     <= ASM0;
      tri_valid <= 1'b0;
    end else begin
      case (state)
        ASM0: if (pop) begin
          tri_v0 <= rdata[ENTRY_W-1:COLOR_W];
          tri_c0 <= rdata[COLOR_W-1:0];
          state  <= ASM1;
        end
        ASM1: if (pop) begin
          tri_v1 <= rdata[ENTRY_W-1:COLOR_W];
          tri_c1 <= rdata[COLOR_W-1:0];
          state  <= ASM2;
        end
        ASM2: if (pop) begin
          tri_v2    <= rdata[ENTRY_W-1:COLOR_W];
          tri_c2    <= rdata[COLOR_W-1:0];
          state     <= EMIT;
          tri_valid <= 1'b1;
        end
        EMIT: if (tri_ready) begin
          state     <= ASM0;
          tri_valid <= 1'b0;
        end
        default: state <= ASM0;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: a per-cycle vector table followed by
// hand-written overflow, flush, pop/push, streaming and reset sequences.
module tb_triangle_assembler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fifo_write_en = 1'b0;
  logic [95:0]  vertex_in = '0;
  logic [95:0]  color_in = '0;
  logic         fifo_full;
  logic [3:0]   fifo_count;
  logic         overflow;
  logic         flush = 1'b0;
  logic         tri_valid;
  logic         tri_ready = 1'b0;
  logic [95:0]  tri_v0, tri_v1, tri_v2;
  logic [95:0]  tri_c0, tri_c1, tri_c2;
  logic [1:0]   asm_state;

  int checks = 0;
  int errors = 0;
  logic [191:0] exp_q[$];

  triangle_assembler #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_write_en (fifo_write_en),
    .vertex_in     (vertex_in),
    .color_in      (color_in),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .flush         (flush),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .tri_v0        (tri_v0),
    .tri_v1        (tri_v1),
    .tri_v2        (tri_v2),
    .tri_c0        (tri_c0),
    .tri_c1        (tri_c1),
    .tri_c2        (tri_c2),
    .asm_state     (asm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus data ----------------
  function automatic logic [31:0] fx(input int i);
    case (i)
      0:  fx = 32'h3F800000;
      1:  fx = 32'h40000000;
      2:  fx = 32'h40400000;
      3:  fx = 32'h40800000;
      4:  fx = 32'h40A00000;
      5:  fx = 32'h40C00000;
      6:  fx = 32'h40E00000;
      7:  fx = 32'h41000000;
      8:  fx = 32'h41100000;
      9:  fx = 32'h41200000;
      10: fx = 32'h41300000;
      11: fx = 32'h41400000;
      default: fx = 32'hA5A50000 | 32'(i);
    endcase
  endfunction

  function automatic logic [95:0] vert(input int i);
    vert = {fx(i), 32'(i), ~32'(i)};
  endfunction

  function automatic logic [95:0] col(input int i);
    col = {32'h3F800000, 32'(i * 7), 32'(i) ^ 32'h0000CAFE};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step(input logic we, input int idx, input logic rdy,
                      input logic fl, input logic rst);
    fifo_write_en = we;
    vertex_in     = vert(idx);
    color_in      = col(idx);
    tri_ready     = rdy;
    flush         = fl;
    reset         = rst;
    @(posedge clk);
    #1;
    fifo_write_en = 1'b0;
    flush         = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Waits for tri_valid (tri_ready must already be high), checks the three
  // slots, then lets the handshake edge pass.
  task automatic wait_tri(input string name, input int a, input int b, input int c);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tri_valid) begin
        seen = 1;
        break;
      end
    end
    chk({name, " valid"}, 192'(seen), 192'd1);
    if (seen) begin
      chk({name, " v0"}, {tri_v0, tri_c0}, {vert(a), col(a)});
      chk({name, " v1"}, {tri_v1, tri_c1}, {vert(b), col(b)});
      chk({name, " v2"}, {tri_v2, tri_c2}, {vert(c), col(c)});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, we, rdy, fl;
    logic        vld;
    logic [3:0]  cnt;
    logic [1:0]  st;
    logic [31:0] v0x, v2x;
  } vec_t;

  function automatic vec_t mk(input int rst, input int we, input int rdy, input int fl,
                              input int vld, input int cnt, input int st,
                              input logic [31:0] v0x, input logic [31:0] v2x);
    vec_t v;
    v.rst = rst[0];
    v.we  = we[0];
    v.rdy = rdy[0];
    v.fl  = fl[0];
    v.vld = vld[0];
    v.cnt = cnt[3:0];
    v.st  = st[1:0];
    v.v0x = v0x;
    v.v2x = v2x;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int n;
    int sent;
    int got;
    logic [191:0] e;
    logic [191:0] slot [3];

    //            rst we rdy fl vld cnt st  v0.x          v2.x
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 1, 0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 1, 1, 32'h0,        32'h0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 2, 32'h0,        32'h0);
    tbl[4]  = mk(0, 0, 1, 0, 1, 0, 3, 32'h3F800000, 32'h40400000);
    tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 1, 0, 32'h0,        32'h0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 1, 1, 32'h0,        32'h0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 1, 2, 32'h0,        32'h0);
    tbl[10] = mk(0, 1, 0, 0, 1, 1, 3, 32'h3F800000, 32'h40400000);
    tbl[11] = mk(0, 1, 0, 0, 1, 2, 3, 32'h3F800000, 32'h40400000);
    tbl[12] = mk(0, 1, 0, 0, 1, 3, 3, 32'h3F800000, 32'h40400000);
    tbl[13] = mk(0, 0, 1, 0, 0, 3, 0, 32'h0,        32'h0);
    tbl[14] = mk(0, 0, 1, 0, 0, 2, 1, 32'h0,        32'h0);
    tbl[15] = mk(0, 0, 1, 0, 0, 1, 2, 32'h0,        32'h0);
    tbl[16] = mk(0, 0, 1, 0, 1, 0, 3, 32'h40800000, 32'h40C00000);
    tbl[17] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0);

    @(posedge clk);
    #1;

    n = 0;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) n = 0;
      step(tbl[i].we, n, tbl[i].rdy, tbl[i].fl, tbl[i].rst);
      if (tbl[i].we) n++;
      chk($sformatf("row%0d tri_valid", i), 192'(tri_valid), 192'(tbl[i].vld));
      chk($sformatf("row%0d fifo_count", i), 192'(fifo_count), 192'(tbl[i].cnt));
      chk($sformatf("row%0d state", i), 192'(asm_state), 192'(tbl[i].st));
      chk($sformatf("row%0d fifo_full", i), 192'(fifo_full), 192'd0);
      chk($sformatf("row%0d overflow", i), 192'(overflow), 192'd0);
      if (tbl[i].vld) begin
        chk($sformatf("row%0d v0.x", i), 192'(tri_v0[95:64]), 192'(tbl[i].v0x));
        chk($sformatf("row%0d v2.x", i), 192'(tri_v2[95:64]), 192'(tbl[i].v2x));
      end
    end

    // ---- fill to full, drop one push, then drain in order ----
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 11; k++) step(1, k, 0, 0, 0);
    chk("fill count", 192'(fifo_count), 192'd8);
    chk("fill full", 192'(fifo_full), 192'd1);
    chk("fill no overflow yet", 192'(overflow), 192'd0);
    step(1, 11, 0, 0, 0);
    chk("drop count", 192'(fifo_count), 192'd8);
    chk("drop overflow", 192'(overflow), 192'd1);
    tri_ready = 1'b1;
    wait_tri("drain t0", 0, 1, 2);
    wait_tri("drain t1", 3, 4, 5);
    wait_tri("drain t2", 6, 7, 8);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("drain partial state", 192'(asm_state), 192'd2);
    chk("drain count", 192'(fifo_count), 192'd0);
    chk("overflow sticky", 192'(overflow), 192'd1);

    // ---- flush discards a partial pair, concurrent push kept ----
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pre-flush state", 192'(asm_state), 192'd2);
    step(1, 2, 1, 1, 0);
    chk("flush state", 192'(asm_state), 192'd0);
    chk("flush valid", 192'(tri_valid), 192'd0);
    chk("flush push kept", 192'(fifo_count), 192'd1);
    step(1, 3, 1, 0, 0);
    step(1, 4, 1, 0, 0);
    wait_tri("post-flush", 2, 3, 4);

    // ---- push and pop on the same edge at count 4 ----
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(1, k, 0, 0, 0);
    chk("held count", 192'(fifo_count), 192'd4);
    chk("held state", 192'(asm_state), 192'd3);
    step(0, 0, 1, 0, 0);
    chk("handshake count", 192'(fifo_count), 192'd4);
    chk("handshake state", 192'(asm_state), 192'd0);
    step(1, 7, 1, 0, 0);
    chk("push+pop count", 192'(fifo_count), 192'd4);
    chk("push+pop state", 192'(asm_state), 192'd1);

    // ---- 20 triangles streamed with random tri_ready ----
    step(0, 0, 0, 0, 1);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 3000 && got < 20; cyc++) begin
      fifo_write_en = (sent < 60) && !fifo_full && ($urandom_range(0, 3) != 0);
      vertex_in     = vert(100 + sent);
      color_in      = col(100 + sent);
      if (fifo_write_en) begin
        exp_q.push_back({vert(100 + sent), col(100 + sent)});
        sent++;
      end
      tri_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (tri_valid && tri_ready) begin
        slot[0] = {tri_v0, tri_c0};
        slot[1] = {tri_v1, tri_c1};
        slot[2] = {tri_v2, tri_c2};
        for (int s = 0; s < 3; s++) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("stream tri%0d slot%0d queue", got, s), 192'd0, 192'd1);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("stream tri%0d slot%0d", got, s), slot[s], e);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    fifo_write_en = 1'b0;
    chk("stream triangles", 192'(got), 192'd20);
    step(0, 0, 1, 0, 0);
    chk("stream queue empty", 192'(exp_q.size()), 192'd0);
    chk("stream count", 192'(fifo_count), 192'd0);
    chk("stream overflow", 192'(overflow), 192'd0);

    // ---- reset while emitting with count 5 ----
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) step(1, k, 0, 0, 0);
    chk("emit count", 192'(fifo_count), 192'd5);
    chk("emit valid", 192'(tri_valid), 192'd1);
    step(1, 8, 1, 1, 1);
    chk("reset valid", 192'(tri_valid), 192'd0);
    chk("reset count", 192'(fifo_count), 192'd0);
    chk("reset overflow", 192'(overflow), 192'd0);
    chk("reset full", 192'(fifo_full), 192'd0);
    chk("reset state", 192'(asm_state), 192'd0);
    chk("reset slots", {tri_v0, tri_c2}, 192'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
